frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 25, number of LEDs on the strip; 3*NUM_LEDS SHALL be at most 256.
REQ-002 SHALL have parameter LED_STEP, default 10, per-LED colour phase increment.
REQ-003 SHALL have parameter GAP_CYCLES, default 100, idle cycles between frames; minimum 1.
REQ-004 SHALL have parameter FLUSH_TIMEOUT, default 1024, maximum cycles to wait for flushing to rise.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit, run frames continuously while high.
REQ-008 SHALL have port flushing, input, 1 bit, downstream strip controller busy shifting out its buffer.
REQ-009 SHALL have port write_en, output, 1 bit, byte-write strobe to the strip controller.
REQ-010 SHALL have port write_addr, output, 8 bits, byte address; LED i uses bytes 3i, 3i+1, 3i+2.
REQ-011 SHALL have port write_data, output, 8 bits, colour byte.
REQ-012 SHALL have port flush, output, 1 bit, request to the strip controller to shift out its buffer.
REQ-013 SHALL have port frame_count, output, 8 bits, number of completed frames, mod 256.
REQ-014 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-015 SHALL have port timeout, output, 1 bit, sticky flush-handshake failure flag.

Function
REQ-016 SHALL implement the states IDLE, WRITE, FLUSH_REQ, FLUSH_WAIT and GAP.
REQ-017 In IDLE with enable=1, SHALL go to WRITE on the next cycle; first write_en=1 with write_addr=0 in that cycle.
REQ-018 In WRITE, SHALL assert write_en for exactly 3*NUM_LEDS consecutive cycles, with write_addr going 0..3*NUM_LEDS-1 in steps of 1.
REQ-019 SHALL set write_data = (led*LED_STEP + frame_count + ch*85) mod 256, where led = addr/3 and ch = addr%3.
REQ-020 SHALL derive led and ch from incrementing counters, not from a divider.
REQ-021 After the last byte, SHALL enter FLUSH_REQ with flush=1 and write_en=0; write_addr and write_data are don't-care when write_en=0.
REQ-022 In FLUSH_REQ, SHALL hold flush=1 until flushing=1 is sampled, then go to FLUSH_WAIT with flush=0.
REQ-023 In FLUSH_REQ, if flushing stays low for FLUSH_TIMEOUT cycles, SHALL set timeout=1, drop flush, increment frame_count and enter GAP.
REQ-024 In FLUSH_WAIT, SHALL stay until flushing=0 is sampled, then increment frame_count (wrapping 255->0) and enter GAP.
REQ-025 In GAP, SHALL count GAP_CYCLES cycles, then go to WRITE if enable=1, otherwise to IDLE.
REQ-026 Deasserting enable during WRITE, FLUSH_REQ or FLUSH_WAIT SHALL NOT abort the frame; the frame completes and the block then returns to IDLE after GAP.
REQ-027 write_en and flush SHALL never be high in the same cycle.
REQ-028 timeout SHALL clear only on reset.

Reset
REQ-029 When reset=0 at a rising clk edge, SHALL set state to IDLE and all outputs to 0, including frame_count and timeout, and zero all counters.
REQ-030 Reset asserted mid-WRITE or mid-flush SHALL take effect on the next edge, abandoning the frame with no further write_en or flush.

Structure
REQ-031 Package frame_writer_pkg SHALL hold the state enum, BYTES_PER_LED=3 and CH_OFFSET=85.
REQ-032 SHALL contain one sub-module, pixel_pattern: a combinational unit mapping (led, ch, frame_count) to write_data; the rest stays in frame_writer.

Verification
REQ-033 Directed test: hold reset=0 for 3 cycles with enable=1 -> all outputs 0 and busy=0.
REQ-034 Directed test: release reset with enable=1, defaults -> addr0=0, addr1=85, addr2=170, addr3=10, addr74=154, with exactly 75 write_en cycles.
REQ-035 Directed test: model flushing high 2 cycles after flush rises, held 600 cycles -> flush drops the cycle after flushing is seen; frame_count=1 after flushing falls; the next WRITE starts 100 cycles later with addr0 data=1.
REQ-036 Directed test: tie flushing=0 -> timeout=1 after 1024 FLUSH_REQ cycles, flush=0, and frames continue.
REQ-037 Directed test: drop enable at write_addr=30 -> write_en remains high through addr 74, the flush handshake completes, and the block sits in IDLE with busy=0.
REQ-038 Directed test: assert reset at write_addr=40 -> the next cycle has write_en=0, frame_count=0 and busy=0; after release the frame restarts at addr 0.

Source files
------------

// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the LED frame writer.
package frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FLUSH_REQ,
    ST_FLUSH_WAIT,
    ST_GAP
  } state_e;

  localparam int BYTES_PER_LED = 3;
  localparam int CH_OFFSET     = 85;

endpackage

// File: rtl/frame_writer_pixel_pattern.sv
// Colour generator: one byte per (led, channel), phase-shifted by the frame count.
module pixel_pattern
  import frame_writer_pkg::*;
#(
  parameter int LED_STEP = 10
) (
  input  logic [7:0] led_i,
  input  logic [1:0] ch_i,
  input  logic [7:0] frame_count_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] STEP8   = 8'(LED_STEP);
  localparam logic [7:0] CH_OFF8 = 8'(CH_OFFSET);

  logic [7:0] led_term;
  logic [7:0] ch_term;

  // All terms are evaluated in 8 bits so the wrap is mod 256 for free.
  assign led_term = led_i * STEP8;
  assign ch_term  = {6'd0, ch_i} * CH_OFF8;
  assign data_o   = led_term + frame_count_i + ch_term;

endmodule

// File: rtl/frame_writer.sv
// Streams one colour frame into a strip controller buffer, requests a flush, then idles.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int NUM_LEDS      = 25,
  parameter int LED_STEP      = 10,
  parameter int GAP_CYCLES    = 100,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       flushing,
  output logic       write_en,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  output logic       flush,
  output logic [7:0] frame_count,
  output logic       busy,
  output logic       timeout
);

  localparam int TO_W  = $clog2(FLUSH_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [7:0]       LAST_ADDR = 8'(BYTES_PER_LED * NUM_LEDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(FLUSH_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       led_q, led_d;
  logic [1:0]       ch_q, ch_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       pixel_data;

  pixel_pattern #(
    .LED_STEP(LED_STEP)
  ) u_pixel_pattern (
    .led_i        (led_q),
    .ch_i         (ch_q),
    .frame_count_i(frame_count_q),
    .data_o       (pixel_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    led_d         = led_q;
    ch_d          = ch_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    timeout_d     = timeout_q;
    write_en      = 1'b0;
    flush         = 1'b0;
    busy          = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        write_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_FLUSH_REQ;
          addr_d  = 8'd0;
          led_d   = 8'd0;
          ch_d    = 2'd0;
        end else begin
          addr_d = addr_q + 8'd1;
          // led/ch track addr/3 and addr%3 without a divider.
          if (ch_q == 2'd2) begin
            ch_d  = 2'd0;
            led_d = led_q + 8'd1;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end

      ST_FLUSH_REQ: begin
        flush = 1'b1;
        if (flushing) begin
          state_d  = ST_FLUSH_WAIT;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_GAP;
          to_cnt_d      = '0;
          timeout_d     = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_FLUSH_WAIT: begin
        if (!flushing) begin
          state_d       = ST_GAP;
          frame_count_d = frame_count_q + 8'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = enable ? ST_WRITE : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= 8'd0;
      led_q         <= 8'd0;
      ch_q          <= 2'd0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      led_q         <= led_d;
      ch_q          <= ch_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
    end
  end

  // Data bus is forced to zero outside WRITE so idle/reset outputs read as 0.
  assign write_addr  = addr_q;
  assign write_data  = write_en ? pixel_data : 8'd0;
  assign frame_count = frame_count_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed/randomized bench for frame_writer with a strip-controller model driving flushing.
`timescale 1ns/1ps
module tb_frame_writer;

  localparam int N_LEDS = 25;
  localparam int STEP   = 10;
  localparam int GAP    = 100;
  localparam int TO     = 1024;
  localparam int NBYTES = 3 * N_LEDS;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       flushing;
  logic       write_en;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       flush;
  logic [7:0] frame_count;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int fc_model = 0;
  int to_model = 0;
  logic [7:0] cap [0:255];

  frame_writer #(
    .NUM_LEDS     (N_LEDS),
    .LED_STEP     (STEP),
    .GAP_CYCLES   (GAP),
    .FLUSH_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flushing   (flushing),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .flush      (flush),
    .frame_count(frame_count),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference colour rule straight from the byte address.
  function automatic logic [7:0] model_data(input int addr, input int fc);
    int v;
    v = ((addr / 3) * STEP + fc + (addr % 3) * 85) % 256;
    return 8'(v);
  endfunction

  task automatic write_frame(input int drop_at, input int rst_at);
    int seen;
    seen = 0;
    for (int a = 0; a < NBYTES; a++) begin
      tick();
      if (write_en === 1'b1) seen++;
      chk("wr_en", write_en, 1);
      chk("wr_addr", write_addr, a);
      chk("wr_data", write_data, model_data(a, fc_model));
      chk("wr_no_flush", flush, 0);
      if (a == 0) chk("timeout_sticky", timeout, to_model);
      cap[a] = write_data;
      if (a == drop_at) enable = 1'b0;
      if (a == rst_at) begin
        reset = 1'b0;
        return;
      end
    end
    tick();
    if (write_en === 1'b1) seen++;
    chk("wr_count", seen, NBYTES);
    chk("flush_rise", flush, 1);
    chk("flush_no_wr", write_en, 0);
  endtask

  task automatic handshake(input int dly, input int hold);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("flush_hold", flush, 1);
    end
    flushing = 1'b1;
    tick();
    chk("flush_drop", flush, 0);
    chk("wait_busy", busy, 1);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("wait_no_flush", flush, 0);
      chk("wait_no_wr", write_en, 0);
      chk("wait_fc", frame_count, fc_model % 256);
    end
    flushing = 1'b0;
    tick();
    fc_model = (fc_model + 1) % 256;
    chk("fc_inc", frame_count, fc_model);
    chk("gap_entry_busy", busy, 1);
    chk("gap_entry_flush", flush, 0);
  endtask

  task automatic timeout_run();
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_flush_held", flush, 1);
      chk("to_flag_early", timeout, to_model);
    end
    tick();
    fc_model = (fc_model + 1) % 256;
    to_model = 1;
    chk("to_flag", timeout, 1);
    chk("to_flush_drop", flush, 0);
    chk("to_fc", frame_count, fc_model);
    chk("to_busy", busy, 1);
  endtask

  task automatic gap_wait(input bit expect_idle);
    for (int i = 1; i < GAP; i++) begin
      tick();
      chk("gap_no_wr", write_en, 0);
      chk("gap_busy", busy, 1);
    end
    if (expect_idle) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_no_wr", write_en, 0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    flushing = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", write_en, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);

    // Frame 0 with fixed reference bytes.
    reset = 1'b1;
    write_frame(-1, -1);
    chk("f0_addr0", cap[0], 0);
    chk("f0_addr1", cap[1], 85);
    chk("f0_addr2", cap[2], 170);
    chk("f0_addr3", cap[3], 10);
    chk("f0_addr74", cap[74], 154);
    handshake(2, 600);
    gap_wait(1'b0);

    write_frame(-1, -1);
    chk("f1_addr0", cap[0], 1);
    handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)));
    gap_wait(1'b0);

    write_frame(-1, -1);
    timeout_run();
    gap_wait(1'b0);

    write_frame(-1, -1);
    handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)));
    gap_wait(1'b0);

    // Dropping enable mid-frame must not cut the frame short.
    write_frame(30, -1);
    handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)));
    gap_wait(1'b1);
    repeat (5) tick();
    chk("idle_stay_busy", busy, 0);
    chk("idle_timeout", timeout, 1);
    chk("idle_fc", frame_count, fc_model);

    // Reset in the middle of a frame.
    enable = 1'b1;
    write_frame(-1, 40);
    tick();
    fc_model = 0;
    to_model = 0;
    chk("mrst_wr_en", write_en, 0);
    chk("mrst_fc", frame_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_flush", flush, 0);
    chk("mrst_timeout", timeout, 0);
    reset = 1'b1;
    write_frame(-1, -1);
    handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)));
    chk("final_fc", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
